// File: rtl/data_ram_responder.sv
// data_ram_responder: data memory behind the MEM stage's data port.
// Read data is registered and arrives one clock after the address.
// Writes are byte-lane masked and write-first with respect to both read ports.
// Also provides a debug read port, a sticky out-of-range store flag and a store counter.
// Optional build macro DM_INIT_CLEAR_EN: when defined, INIT clears every word
// to zero, one word per cycle, before the array reports ready.
module data_ram_responder #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      dm_addr,
  input  logic [3:0]       dm_wen,
  input  logic [31:0]      dm_wdata,
  output logic [31:0]      dm_rdata,
  input  logic [31:0]      test_addr,
  output logic [31:0]      test_data,
  output logic             dm_ready,
  output logic             addr_err,
  output logic [CNT_W-1:0] store_cnt
);

  typedef enum logic {INIT, READY} state_t;

  state_t state_q, state_d;

  logic [31:0]       mem [2**ADDR_W];
  logic [ADDR_W-1:0] dm_idx;
  logic [ADDR_W-1:0] test_idx;
  logic              dm_in_range;
  logic              test_in_range;
  logic              is_ready;
  logic              wr_accept;
  logic [31:0]       merged_word;
  logic              clr_done;
  logic              clr_wr;
  logic [ADDR_W-1:0] clr_idx;
  logic              unused_addr_bits;

  assign dm_idx        = dm_addr[ADDR_W+1:2];
  assign test_idx      = test_addr[ADDR_W+1:2];
  assign dm_in_range   = (dm_addr[31:ADDR_W+2] == '0);
  assign test_in_range = (test_addr[31:ADDR_W+2] == '0);
  assign is_ready      = (state_q == READY);
  assign dm_ready      = is_ready;

  // Addresses are word aligned; the byte offset bits carry no information here.
  assign unused_addr_bits = &{1'b0, dm_addr[1:0], test_addr[1:0]};

  // A store lands only when ready, in range, and not in a reset cycle.
  assign wr_accept = is_ready && !reset && dm_in_range && (dm_wen != 4'b0000);

`ifdef DM_INIT_CLEAR_EN
  logic [ADDR_W:0] clr_ptr;

  assign clr_done = clr_ptr[ADDR_W];
  assign clr_wr   = (state_q == INIT) && !reset && !clr_done;
  assign clr_idx  = clr_ptr[ADDR_W-1:0];

  // Clear pointer walks every word once during INIT; reset restarts it at 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_ptr <= '0;
    end else if (clr_wr) begin
      clr_ptr <= clr_ptr + 1'b1;
    end
  end
`else
  assign clr_done = 1'b1;
  assign clr_wr   = 1'b0;
  assign clr_idx  = '0;
`endif

  // State register: reset always parks the FSM in INIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave INIT once clearing (if any) is finished, then stay READY.
  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (clr_done) state_d = READY;
      READY:   state_d = READY;
      default: state_d = INIT;
    endcase
  end

  // Word as it will look after this cycle's store: enabled lanes from wdata.
  always_comb begin
    merged_word = mem[dm_idx];
    for (int i = 0; i < 4; i++) begin
      if (dm_wen[i]) merged_word[8*i +: 8] = dm_wdata[8*i +: 8];
    end
  end

  // Array update: clearing during INIT, otherwise byte-masked stores.
  always_ff @(posedge clk) begin
    if (clr_wr) begin
      mem[clr_idx] <= '0;
    end else if (wr_accept) begin
      for (int i = 0; i < 4; i++) begin
        if (dm_wen[i]) mem[dm_idx][8*i +: 8] <= dm_wdata[8*i +: 8];
      end
    end
  end

  // Registered outputs: read ports are write-first, flag is sticky, counter wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      dm_rdata  <= '0;
      test_data <= '0;
      addr_err  <= 1'b0;
      store_cnt <= '0;
    end else begin
      dm_rdata <= (is_ready && dm_in_range) ? merged_word : 32'h0;

      if (is_ready && test_in_range) begin
        test_data <= (wr_accept && (test_idx == dm_idx)) ? merged_word : mem[test_idx];
      end else begin
        test_data <= 32'h0;
      end

      if (is_ready && !dm_in_range && (dm_wen != 4'b0000)) begin
        addr_err <= 1'b1;
      end

      if (wr_accept) begin
        store_cnt <= store_cnt + CNT_W'(1);
      end
    end
  end

endmodule
